// File: rtl/core_pkg.sv
// Shared types and constants for the hazard / forwarding logic of the 5-stage core.
package core_pkg;

    // Operand-mux select codes driven into the EX stage.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_WBR   = 2'b11;

    // Register indices are carried at a fixed width so the stage structs can live
    // here; the top zero-extends its REG_ADDR_W-wide ports (REG_ADDR_W <= RA_MAX).
    localparam int RA_MAX = 8;
    typedef logic [RA_MAX-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // Destination info tracked for MEM, WB and WB+1.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
    } stage_t;

    // Full instruction info tracked for EX.
    typedef struct packed {
        logic     valid;
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     use1;
        logic     use2;
        reg_idx_t rd;
        logic     we;
        logic     mr;
    } ex_stage_t;

    // A stage writes r when it holds a real register-writing instruction to r (x0 never counts).
    function automatic logic writes_reg(input stage_t s, input reg_idx_t r);
        return s.valid && s.we && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority match of one EX source register against the MEM, WB and WB+1 writers.
module fwd_select
    import core_pkg::*;
(
    input  reg_idx_t   src,
    input  logic       use_src,
    input  stage_t     mem_st,
    input  stage_t     wb_st,
    input  stage_t     wbr_st,
    output logic [1:0] sel
);

    // Youngest writer wins: MEM, then WB, then WB+1, else the register file.
    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (writes_reg(mem_st, src)) begin
                sel = FWD_EXMEM;
            end else if (writes_reg(wb_st, src)) begin
                sel = FWD_WB;
            end else if (writes_reg(wbr_st, src)) begin
                sel = FWD_WBR;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand-forwarding selects plus load-use / memory-wait stall control for the 5-stage core.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; flush squashes, load-use requests a 1-cycle stall
// LU_STALL | bubble is in EX, load has moved on; no stall outputs
// MEM_WAIT | data memory busy; whole pipeline and shadows frozen
module hazard_forward_unit
    import core_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  mem_stall,
    output logic [1:0]            forward_A,
    output logic [1:0]            forward_B,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  freeze,
    output logic [CNT_W-1:0]      stall_count
);

    hz_state_t state, state_next;
    ex_stage_t ex_st, ex_next;
    stage_t    mem_st, wb_st, wbr_st;
    reg_idx_t  rs1_x, rs2_x, rd_x;
    logic      load_use;

    assign rs1_x = reg_idx_t'(id_rs1);
    assign rs2_x = reg_idx_t'(id_rs2);
    assign rd_x  = reg_idx_t'(id_rd);

    // Load in EX whose destination the ID instruction actually reads.
    always_comb begin
        load_use = id_valid && ex_st.valid && ex_st.mr && (ex_st.rd != '0) &&
                   ((id_use_rs1 && (rs1_x == ex_st.rd)) ||
                    (id_use_rs2 && (rs2_x == ex_st.rd)));
    end

    // Next-state and stall/bubble/freeze decode; mem_stall beats flush beats load-use.
    always_comb begin
        state_next   = state;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        freeze       = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                end else if (flush) begin
                    bubble_id_ex = 1'b1;
                end else if (load_use) begin
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    state_next   = LU_STALL;
                end
            end
            LU_STALL: begin
                state_next = mem_stall ? MEM_WAIT : RUN;
            end
            MEM_WAIT: begin
                freeze = 1'b1;
                if (!mem_stall) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // What EX captures on an advancing edge: the ID instruction, or an empty slot.
    always_comb begin
        ex_next = '0;
        if (id_valid && !bubble_id_ex) begin
            ex_next.valid = 1'b1;
            ex_next.rs1   = rs1_x;
            ex_next.rs2   = rs2_x;
            ex_next.use1  = id_use_rs1;
            ex_next.use2  = id_use_rs2;
            ex_next.rd    = rd_x;
            ex_next.we    = id_reg_write;
            ex_next.mr    = id_mem_read;
        end
    end

    // Shadow pipeline ID->EX->MEM->WB->WBR; holds while frozen.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_st  <= '0;
            mem_st <= '0;
            wb_st  <= '0;
            wbr_st <= '0;
        end else if (!freeze) begin
            ex_st        <= ex_next;
            mem_st.valid <= ex_st.valid;
            mem_st.rd    <= ex_st.rd;
            mem_st.we    <= ex_st.we;
            wb_st        <= mem_st;
            wbr_st       <= wb_st;
        end
    end

    // Saturating count of cycles in which the front end or whole pipe is held.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_count <= '0;
        end else if ((stall_if_id || freeze) && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    fwd_select u_fwd_a (
        .src     (ex_st.rs1),
        .use_src (ex_st.valid && ex_st.use1),
        .mem_st  (mem_st),
        .wb_st   (wb_st),
        .wbr_st  (wbr_st),
        .sel     (forward_A)
    );

    fwd_select u_fwd_b (
        .src     (ex_st.rs2),
        .use_src (ex_st.valid && ex_st.use2),
        .mem_st  (mem_st),
        .wb_st   (wb_st),
        .wbr_st  (wbr_st),
        .sel     (forward_B)
    );

endmodule
